// File: rtl/result_uart_if.sv
// Result-to-UART bus: the CPU result value and send request in, serial line and status out.
interface result_uart_if;
  logic [15:0] result_reg;
  logic        force_send;
  logic        tx;
  logic        busy;
  logic        frame_done;

  modport master (
    output result_reg,
    output force_send,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  result_reg,
    input  force_send,
    output tx,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/result_uart_tx.sv
// Sends result_reg as "HHHH\r\n" over 8N1 UART whenever it changes or a send is forced.
// A snapshot is taken at frame start; changes during a frame are dropped in favour of the latest value.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          pc_reset,
  result_uart_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'd5;
  localparam logic [2:0]  BIT_LAST  = 3'd7;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] last_sent_q, last_sent_d;
  logic [15:0] snap_q, snap_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic        baud_tc;
  logic        trigger;
  logic [7:0]  char_nxt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_char(input logic [2:0] idx, input logic [15:0] val);
    logic [7:0] c;
    case (idx)
      3'd0:    c = hex_ascii(val[15:12]);
      3'd1:    c = hex_ascii(val[11:8]);
      3'd2:    c = hex_ascii(val[7:4]);
      3'd3:    c = hex_ascii(val[3:0]);
      3'd4:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  assign baud_tc = (baud_q == BAUD_LAST);
  assign trigger = (bus.result_reg != last_sent_q) || bus.force_send;

  // State register; the snapshot is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      state_q      <= S_IDLE;
      baud_q       <= 16'h0000;
      bit_q        <= 3'd0;
      idx_q        <= 3'd0;
      last_sent_q  <= 16'h0000;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      last_sent_q  <= last_sent_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  // Next-state logic: every bit period ends on the baud terminal count.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    last_sent_d = last_sent_q;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'h0000;
        bit_d  = 3'd0;
        if (trigger) begin
          snap_d      = bus.result_reg;
          last_sent_d = bus.result_reg;
          idx_d       = 3'd0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = 16'h0000;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'h0001;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = 16'h0000;
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'h0001;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d = 16'h0000;
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 16'h0001;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so tx/busy come straight from flops.
  always_comb begin
    char_nxt     = frame_char(idx_d, snap_d);
    tx_d         = 1'b1;
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_q == S_STOP) && baud_tc && (idx_q == IDX_LAST);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = char_nxt[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the CPU's result_reg output.
- Whenever the result value changes, or a send is forced, it snapshots the value and transmits it over a UART TX line as an ASCII frame: 4 uppercase hex digits, MSB nibble first, then CR, then LF.
- Gives the board a serial view of program results without halting the core.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (legal range 1..65535).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- pc_reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- result_reg  input  16  live result value from the CPU.
- force_send  input  1  request to send the current result_reg even if unchanged; level, sampled only in IDLE.
- tx  output  1  UART serial out: 8N1, LSB first, idle high.
- busy  output  1  high from frame start through the last stop bit.
- frame_done  output  1  one-cycle pulse on completion of a frame.

Behaviour:
- Reset, when pc_reset=0 at a rising edge:
  - tx=1, busy=0, frame_done=0, state=IDLE.
  - last_sent=16'h0000; char index=0; bit and baud counters=0.
  - Reset overrides everything, including mid-frame; tx returns high the following cycle.
- Trigger, checked only in IDLE: (result_reg != last_sent) OR force_send=1. On the triggering edge:
  - snap <= result_reg, last_sent <= result_reg, char index <= 0.
  - State <= START, busy <= 1, tx <= 0 (registered, so tx falls the cycle after the trigger edge).
- Character sequence, idx 0..5: hex(snap[15:12]), hex(snap[11:8]), hex(snap[7:4]), hex(snap[3:0]), 8'h0D, 8'h0A.
- Hex encoding: nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h41+(n-10), uppercase only.
- States:
  - IDLE: tx=1, busy=0. Trigger -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit=0.
  - DATA: tx=char[bit] for CLKS_PER_BIT cycles each; after bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If idx<5, idx++ and go to START with no gap between characters. If idx==5 -> IDLE, busy<=0, frame_done<=1 for one cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1; advances the bit at terminal count. CLKS_PER_BIT=1 gives one cycle per bit.
- Frame length: exactly 60*CLKS_PER_BIT cycles, measured from tx falling to busy falling.
- tx is a registered output, glitch-free.
- result_reg changes while busy: ignored; snap is held for the whole frame.
- After the frame: the first IDLE cycle compares the current result_reg against last_sent, so only the latest value is sent and intermediate values are dropped.
- Minimum IDLE: one cycle between frames, during which busy=0. A retrigger is evaluated in that cycle.
- force_send while busy: ignored, not queued.
- After reset, result_reg=0 alone does not trigger, because it equals last_sent.

Test Plan:
- Reset held 5 cycles with result_reg=16'h1234 -> tx=1, busy=0, frame_done=0 throughout. Release -> frame starts on the first post-reset edge.
- CLKS_PER_BIT=4, result_reg 0 -> 16'h1A2F:
  - Decoded bytes 31 41 32 46 0D 0A.
  - Each bit lasts 4 cycles; busy high for 240 cycles; one frame_done pulse.
- Mid-frame result_reg changes 16'h00FF -> 16'hBEEF -> 16'hC0DE during character 2:
  - First frame sends "00FF\r\n".
  - Next frame sends "C0DE\r\n"; BEEF is never sent.
- force_send=1 with result_reg unchanged at 16'hC0DE in IDLE -> "C0DE\r\n" resent. Holding force_send high -> back-to-back frames with a 1-cycle IDLE gap.
- pc_reset=0 during DATA of character 3:
  - tx=1 and busy=0 the next cycle.
  - After release with result_reg=16'h0000: no frame is sent.
- CLKS_PER_BIT=1, result_reg=16'h000A -> bytes 30 30 30 41 0D 0A at one bit per cycle; frame is 60 cycles long.
